// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between an instruction
// fetch port and a data load/store port. Data accesses win by default. After
// MAX_DATA_RUN data grants in a row while a fetch waits, the fetch wins once.
// Each access takes two cycles: an issue cycle in IDLE, then a completion cycle
// in FETCH or DATA.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int MAX_DATA_RUN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int CNT_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_run_cnt;
  logic [CNT_W-1:0] w_run_cnt_nxt;
  logic             r_is_wr;
  logic [31:0]      r_if_rdata;
  logic [31:0]      r_mem_rdata;

  logic             w_data_req;
  logic             w_grant_data;
  logic             w_grant_fetch;
  logic             w_unused;

  // Upper address bits are not routed to the memory.
  assign w_unused = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  // Arbitration is suppressed while reset is asserted. This keeps m_en low even though the state is IDLE.
  assign w_data_req    = mem_rd | mem_wr;
  assign w_grant_data  = rst && (r_state == S_IDLE) && w_data_req &&
                         !(if_req && (r_run_cnt == RUN_MAX));
  assign w_grant_fetch = rst && (r_state == S_IDLE) && if_req && !w_grant_data;

  // Read data is bypassed straight from memory during the done cycle, then held.
  assign if_rdata  = (r_state == S_FETCH) ? m_rdata : r_if_rdata;
  assign mem_rdata = (r_state == S_DATA && !r_is_wr) ? m_rdata : r_mem_rdata;

  // Stall requests hold the pipeline until the matching done pulse.
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = w_data_req & ~mem_done;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state and memory-side outputs. Memory signals are driven only in the IDLE issue cycle.
  always_comb begin
    w_next   = r_state;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    if_valid = 1'b0;
    mem_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_data) begin
          m_en    = 1'b1;
          m_we    = mem_wr;
          m_addr  = mem_addr[ADDR_W-1:0];
          m_wdata = mem_wdata;
          w_next  = S_DATA;
        end else if (w_grant_fetch) begin
          m_en    = 1'b1;
          m_addr  = if_addr[ADDR_W-1:0];
          w_next  = S_FETCH;
        end
      end
      S_FETCH: begin
        if_valid = 1'b1;
        w_next   = S_IDLE;
      end
      S_DATA: begin
        mem_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Data-run counter: counts data grants that made a fetch wait, saturating at the limit.
  always_comb begin
    w_run_cnt_nxt = r_run_cnt;
    if (rst && r_state == S_IDLE) begin
      if (w_grant_data && if_req) begin
        if (r_run_cnt != RUN_MAX) w_run_cnt_nxt = r_run_cnt + 1'b1;
      end else if (w_grant_fetch || !if_req) begin
        w_run_cnt_nxt = '0;
      end
    end
  end

  // Run counter and write flag for the access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_cnt <= '0;
      r_is_wr   <= 1'b0;
    end else begin
      r_run_cnt <= w_run_cnt_nxt;
      if (w_grant_data) r_is_wr <= mem_wr;
    end
  end

  // Read-data holding registers, loaded on the completion cycle. Writes leave mem_rdata unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (r_state == S_FETCH)             r_if_rdata  <= m_rdata;
      if (r_state == S_DATA && !r_is_wr)  r_mem_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch, data/fetch priority,
// starvation relief, store, address truncation and reset during a fetch.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        m_en;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        stall_if;
  logic        stall_mem;

  int total = 0;
  int bad   = 0;

  unified_mem_arbiter #(.ADDR_W(8), .MAX_DATA_RUN(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .m_en      (m_en),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start a new cycle: inputs change just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic fetch_turn;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0; m_rdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ifv",   if_valid,  0);
    chk("rst_done",  mem_done,  0);
    chk("rst_men",   m_en,      0);
    chk("rst_mwe",   m_we,      0);
    chk("rst_ifrd",  if_rdata,  0);
    chk("rst_memrd", mem_rdata, 0);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("idle_men", m_en, 0);

    // Fetch only
    tick(); if_req = 1'b1; if_addr = 32'h10; m_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("f_men",    m_en,     1);
    chk("f_maddr",  m_addr,   32'h10);
    chk("f_mwe",    m_we,     0);
    chk("f_stall0", stall_if, 1);
    chk("f_ifv0",   if_valid, 0);
    tick();
    @(negedge clk);
    chk("f_ifv1",   if_valid, 1);
    chk("f_ifrd1",  if_rdata, 32'h0050_0093);
    chk("f_stall1", stall_if, 0);
    chk("f_men1",   m_en,     0);
    tick(); if_req = 1'b0; m_rdata = 32'hCAFE_0000;
    @(negedge clk);
    chk("f_hold_ifv", if_valid, 0);
    chk("f_hold_rd",  if_rdata, 32'h0050_0093);

    // Simultaneous fetch and load: data first, then fetch
    tick(); if_req = 1'b1; if_addr = 32'h40; mem_rd = 1'b1; mem_addr = 32'h24;
    m_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("s_men0",   m_en,      1);
    chk("s_maddr0", m_addr,    32'h24);
    chk("s_stif0",  stall_if,  1);
    chk("s_stmem0", stall_mem, 1);
    tick();
    @(negedge clk);
    chk("s_done1",  mem_done,  1);
    chk("s_mrd1",   mem_rdata, 32'h1111_2222);
    chk("s_stmem1", stall_mem, 0);
    chk("s_ifv1",   if_valid,  0);
    tick(); mem_rd = 1'b0;
    @(negedge clk);
    chk("s_men2",   m_en,      1);
    chk("s_maddr2", m_addr,    32'h40);
    tick(); m_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("s_ifv3",   if_valid,  1);
    chk("s_ifrd3",  if_rdata,  32'h3333_4444);
    chk("s_mrdh3",  mem_rdata, 32'h1111_2222);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("s_men4", m_en, 0);

    // Starvation relief: grants go D,D,D,F,D,D,D,F
    fetch_turn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) begin
        if_req = 1'b1; if_addr = 32'h50; mem_rd = 1'b1; mem_addr = 32'h30;
        m_rdata = 32'hA5A5_A5A5;
      end
      @(negedge clk);
      if (i % 2 == 0) begin
        fetch_turn = ((i / 2) % 4 == 3);
        chk("st_men",  m_en,   1);
        chk("st_addr", m_addr, fetch_turn ? 32'h50 : 32'h30);
      end else begin
        chk("st_ifv",  if_valid, fetch_turn ? 1 : 0);
        chk("st_done", mem_done, fetch_turn ? 0 : 1);
      end
    end
    tick(); if_req = 1'b0; mem_rd = 1'b0;
    @(negedge clk);
    chk("st_men_end", m_en, 0);

    // Store
    tick(); mem_wr = 1'b1; mem_addr = 32'h08; mem_wdata = 32'hDEAD_BEEF;
    m_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("w_men",   m_en,    1);
    chk("w_mwe",   m_we,    1);
    chk("w_maddr", m_addr,  32'h08);
    chk("w_wdata", m_wdata, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("w_done",  mem_done,  1);
    chk("w_mwe1",  m_we,      0);
    chk("w_mrd",   mem_rdata, 32'hA5A5_A5A5);
    tick(); mem_wr = 1'b0;
    @(negedge clk);
    chk("w_mrd_hold", mem_rdata, 32'hA5A5_A5A5);

    // Address truncation
    tick(); if_req = 1'b1; if_addr = 32'h0000_01FC; m_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("t_maddr", m_addr, 32'hFC);
    tick();
    @(negedge clk);
    chk("t_ifv", if_valid, 1);
    tick(); if_req = 1'b0;
    @(negedge clk);

    // Reset while in FETCH
    tick(); if_req = 1'b1; if_addr = 32'h20; m_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("r_men0", m_en, 1);
    tick(); rst = 1'b0;
    #1;
    chk("r_ifv_now",  if_valid,  0);
    chk("r_ifrd_now", if_rdata,  0);
    chk("r_mrd_now",  mem_rdata, 0);
    chk("r_men_now",  m_en,      0);
    @(negedge clk);
    chk("r_ifv_a", if_valid, 0);
    chk("r_men_a", m_en,     0);
    tick();
    @(negedge clk);
    chk("r_ifv_b", if_valid, 0);
    chk("r_men_b", m_en,     0);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("r_men_rel",  m_en,     1);
    chk("r_addr_rel", m_addr,   32'h20);
    chk("r_ifv_rel",  if_valid, 0);
    tick();
    @(negedge clk);
    chk("r_ifv_done",  if_valid, 1);
    chk("r_ifrd_done", if_rdata, 32'h7777_7777);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("r_ifrd_hold", if_rdata, 32'h7777_7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: width of the memory-side byte address.
REQ-002 Parameter MAX_DATA_RUN, default 3: maximum consecutive data grants while a fetch waits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch request; held high until if_valid.
REQ-006 if_addr  input  32  fetch byte address (PC).
REQ-007 if_valid  output  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction.
REQ-009 mem_rd, mem_wr  input  1 each  data read/write request; held until mem_done; never both high.
REQ-010 mem_addr  input  32  data byte address.
REQ-011 mem_wdata  input  32  store data.
REQ-012 mem_done  output  1  one-cycle pulse; access complete; mem_rdata valid for reads.
REQ-013 mem_rdata  output  32  load data.
REQ-014 m_en, m_we  output  1 each  memory enable/write enable.
REQ-015 m_addr  output  ADDR_W  memory byte address = requester address[ADDR_W-1:0].
REQ-016 m_wdata  output  32  write data to memory.
REQ-017 m_rdata  input  32  memory read data, valid the cycle after m_en.
REQ-018 stall_if, stall_mem  output  1 each  pipeline stall requests.

Function
REQ-019 FSM states IDLE, FETCH, DATA; only IDLE arbitrates.
REQ-020 In IDLE with a request pending, the arbiter drives m_en=1 combinationally that cycle for the winner, with m_addr/m_we/m_wdata from that requester; next state FETCH or DATA.
REQ-021 In FETCH/DATA: m_en=0, m_we=0; the arbiter latches m_rdata into if_rdata/mem_rdata, pulses if_valid or mem_done for exactly that cycle, and returns to IDLE at the next edge.
REQ-022 Access latency: 2 cycles from the arbitration cycle to the done pulse; a single requester gets at most one access per 2 cycles.
REQ-023 Priority: data (mem_rd|mem_wr) wins over fetch, except when run_cnt == MAX_DATA_RUN, in which case fetch wins.
REQ-024 run_cnt: increments on each data grant made while if_req=1; clears to 0 on any fetch grant or on any arbitration cycle with if_req=0; saturates at MAX_DATA_RUN.
REQ-025 Writes: m_we=1 only in the DATA issue cycle; mem_done still pulses the following cycle; mem_rdata is unchanged on writes.
REQ-026 if_rdata/mem_rdata hold their last value between done pulses.
REQ-027 stall_if = if_req & ~if_valid; stall_mem = (mem_rd|mem_wr) & ~mem_done; both combinational.
REQ-028 Requests seen in IDLE in the same cycle a done pulse is issued elsewhere are not possible (done only in FETCH/DATA); back-to-back requests from the same requester re-arbitrate in the next IDLE.
REQ-029 A request dropped before its done pulse is a protocol violation; behaviour is undefined, with no requirement other than the FSM returning to IDLE.

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, run_cnt=0, if_valid=0, mem_done=0, if_rdata=0, mem_rdata=0, m_en=0, m_we=0.
REQ-031 Reset mid-access discards the in-flight access: no done pulse is issued after reset release; arbitration restarts in the first cycle with rst=1.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0x10, m_rdata=0x00500093 -> m_en=1, m_addr=0x10 in cycle 0; if_valid=1, if_rdata=0x00500093 in cycle 1; stall_if=1 in cycle 0 only.
REQ-033 Simultaneous: if_req=1 and mem_rd=1, mem_addr=0x24 in one cycle -> data granted first (m_addr=0x24, mem_done at +1); fetch issued at +2, with if_valid at +3.
REQ-034 Starvation: mem_rd and if_req held continuously -> grant order D,D,D,F,D,D,D,F; if_valid every 8th cycle.
REQ-035 Store: mem_wr=1, mem_addr=0x08, mem_wdata=0xDEADBEEF -> m_we=1, m_addr=0x08, m_wdata=0xDEADBEEF in one cycle; mem_done next cycle; mem_rdata unchanged.
REQ-036 Reset in FETCH state -> if_valid stays 0, outputs zero immediately, and the re-issued fetch completes 2 cycles after release.
REQ-037 Address truncation: if_addr=0x000001FC with ADDR_W=8 -> m_addr=0xFC.
